// File: rtl/wr_cdb_arbiter_pkg.sv
// Shared types for the writeback/CDB arbiter: FU result packet, CDB slot
// payload, instruction word and the per-slot grant record.
// Also supplies the default CDB count through the CDB_NUM macro.

`ifndef CDB_NUM
`define CDB_NUM 2
`endif

package wr_cdb_arbiter_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ROB_TAG_W   = 5;
  localparam int unsigned FU_IDX_W    = 8;
  localparam int unsigned CDB_NUM_DEF = `CDB_NUM;

  typedef logic [31:0] INST;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
    INST                  inst;
    logic [XLEN-1:0]      NPC;
  } EX_WR_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } CDB_DATA;

  typedef struct packed {
    logic                valid;
    logic [FU_IDX_W-1:0] fu_idx;
  } WR_GRANT;

endpackage

// File: rtl/wr_cdb_arbiter_if.sv
// FU-to-CDB writeback bus.
//   ex_packet_in[FU_NUM] : FU result packets, .valid is the push request
//   ex_ready[FU_NUM]     : per-FU push permission
//   cdb[CDB_NUM]         : registered broadcast slots
//   wr_inst / wr_NPC     : instruction and NPC per slot (0 when slot idle)
// master = FU/consumer side, slave = arbiter.

interface wr_cdb_arbiter_if
  import wr_cdb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM  = 4,
  parameter int unsigned CDB_NUM = CDB_NUM_DEF
);

  EX_WR_PACKET       ex_packet_in [FU_NUM];
  logic [FU_NUM-1:0] ex_ready;
  CDB_DATA           cdb          [CDB_NUM];
  INST               wr_inst      [CDB_NUM];
  logic [XLEN-1:0]   wr_NPC       [CDB_NUM];

  modport master (output ex_packet_in, input ex_ready, cdb, wr_inst, wr_NPC);
  modport slave  (input ex_packet_in, output ex_ready, cdb, wr_inst, wr_NPC);

endinterface

// File: rtl/wr_fu_buffer.sv
// Per-FU writeback FIFO of EX_WR_PACKET.
//   clock, reset (async active-low), push, pop, flush (drops contents and
//   any same-cycle push), din, head, count, full, empty.
// Any depth >= 1 is supported; pointers wrap explicitly at DEPTH.

module wr_fu_buffer
  import wr_cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  EX_WR_PACKET                  din,
  output EX_WR_PACKET                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  EX_WR_PACKET      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy state; flush wins over any push/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage, not reset.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wr_cdb_arbiter.sv
// Buffered multi-bus writeback arbiter: one FIFO per FU, up to CDB_NUM heads
// per cycle win round-robin and are broadcast on registered CDB slots.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   squash : flush all FIFOs and CDB slots (only with WR_SQUASH_EN defined)
//   bus    : wr_cdb_arbiter_if.slave (ex_packet_in, ex_ready, cdb, wr_inst, wr_NPC)
// Optional feature macro: WR_SQUASH_EN.

module wr_cdb_arbiter
  import wr_cdb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM    = 4,
  parameter int unsigned CDB_NUM   = CDB_NUM_DEF,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
`ifdef WR_SQUASH_EN
  input  logic              squash,
`endif
  wr_cdb_arbiter_if.slave   bus
);

  localparam int unsigned FI_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  if (FU_NUM == 0 || CDB_NUM == 0 || CDB_NUM > FU_NUM || BUF_DEPTH == 0 ||
      FU_NUM > (1 << FU_IDX_W)) begin : g_param_err
    $error("wr_cdb_arbiter: illegal FU_NUM/CDB_NUM/BUF_DEPTH combination");
  end

  logic              flush;
  EX_WR_PACKET       head  [FU_NUM];
  logic [CNT_W-1:0]  count [FU_NUM];
  logic [FU_NUM-1:0] full;
  logic [FU_NUM-1:0] empty;
  logic [FU_NUM-1:0] push;
  logic [FU_NUM-1:0] pop;
  logic [FI_W-1:0]   rr_ptr;
  logic [FI_W-1:0]   rr_ptr_nxt;
  WR_GRANT           grant [CDB_NUM];
  EX_WR_PACKET       win   [CDB_NUM];

`ifdef WR_SQUASH_EN
  assign flush = squash;
`else
  assign flush = 1'b0;
`endif

  // Per-FU buffers; ready looks only at the registered count.
  for (genvar i = 0; i < FU_NUM; i++) begin : g_fu
    assign bus.ex_ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
    assign push[i]         = bus.ex_packet_in[i].valid && !full[i];

    wr_fu_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (flush),
      .din   (bus.ex_packet_in[i]),
      .head  (head[i]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // FU index at scan offset 'off' from the round-robin pointer.
  function automatic logic [FI_W-1:0] scan_idx(logic [FI_W-1:0] base, int unsigned off);
    logic [FI_W:0] s;
    s = {1'b0, base} + (FI_W+1)'(off);
    if (s >= (FI_W+1)'(FU_NUM)) s = s - (FI_W+1)'(FU_NUM);
    return s[FI_W-1:0];
  endfunction

  // Round-robin select: slot k takes the k-th non-empty head in scan order.
  always_comb begin
    logic [FI_W-1:0]   idx;
    logic [FU_NUM-1:0] taken;
    taken      = '0;
    idx        = '0;
    pop        = '0;
    rr_ptr_nxt = rr_ptr;
    for (int k = 0; k < CDB_NUM; k++) grant[k] = '0;
    for (int k = 0; k < CDB_NUM; k++) begin
      for (int unsigned o = 0; o < FU_NUM; o++) begin
        idx = scan_idx(rr_ptr, o);
        if (!grant[k].valid && !empty[idx] && !taken[idx]) begin
          grant[k].valid  = 1'b1;
          grant[k].fu_idx = FU_IDX_W'(idx);
          taken[idx]      = 1'b1;
          rr_ptr_nxt      = (idx == FI_W'(FU_NUM - 1)) ? '0 : idx + FI_W'(1);
        end
      end
    end
    pop = taken;
  end

  // Winning packet per slot, all-zero for an idle slot.
  always_comb begin
    for (int k = 0; k < CDB_NUM; k++) begin
      win[k] = grant[k].valid ? head[FI_W'(grant[k].fu_idx)] : '0;
    end
  end

  // Registered broadcast and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int k = 0; k < CDB_NUM; k++) begin
        bus.cdb[k]     <= '0;
        bus.wr_inst[k] <= '0;
        bus.wr_NPC[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < CDB_NUM; k++) begin
        bus.cdb[k]     <= '0;
        bus.wr_inst[k] <= '0;
        bus.wr_NPC[k]  <= '0;
      end
    end else begin
      rr_ptr <= rr_ptr_nxt;
      for (int k = 0; k < CDB_NUM; k++) begin
        bus.cdb[k].valid   <= win[k].valid;
        bus.cdb[k].value   <= win[k].value;
        bus.cdb[k].rob_tag <= win[k].rob_tag;
        bus.wr_inst[k]     <= win[k].inst;
        bus.wr_NPC[k]      <= win[k].NPC;
      end
    end
  end

endmodule

// File: tb/tb_wr_cdb_arbiter.sv
// Bench for wr_cdb_arbiter (FU_NUM=4, CDB_NUM=2, BUF_DEPTH=2). Accepted
// pushes feed per-FU expected queues; a negedge monitor pops and compares
// every broadcast slot. Directed checks cover slot placement and timing.

module tb_wr_cdb_arbiter;
  import wr_cdb_arbiter_pkg::*;

  localparam int FU_N  = 4;
  localparam int CDB_N = 2;

  logic clk;
  logic rst_n;
`ifdef WR_SQUASH_EN
  logic squash;
  wire  sq_now = squash;
`else
  wire  sq_now = 1'b0;
`endif

  wr_cdb_arbiter_if #(.FU_NUM(FU_N), .CDB_NUM(CDB_N)) bus ();

  wr_cdb_arbiter #(.FU_NUM(FU_N), .CDB_NUM(CDB_N), .BUF_DEPTH(2)) dut (
    .clock (clk),
    .reset (rst_n),
`ifdef WR_SQUASH_EN
    .squash(squash),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          cyc   = 0;
  logic        win_en = 1'b0;
  int          wins     [FU_N];
  int          last_win [FU_N];
  int          max_gap  [FU_N];
  EX_WR_PACKET exp_q    [FU_N][$];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic EX_WR_PACKET make_pkt(int fu, int seq);
    EX_WR_PACKET p;
    p.valid   = 1'b1;
    p.value   = 32'hC0DE_0000 | (32'(fu) << 8) | 32'(seq & 255);
    p.rob_tag = 5'(seq);
    p.inst    = 32'h0000_0013 | (32'(seq) << 20) | (32'(fu) << 7);
    p.NPC     = 32'h0001_0000 + 32'(fu) * 32'h100 + 32'(seq) * 4;
    return p;
  endfunction

  function automatic EX_WR_PACKET slot_pkt(int k);
    EX_WR_PACKET p;
    p.valid   = bus.cdb[k].valid;
    p.value   = bus.cdb[k].value;
    p.rob_tag = bus.cdb[k].rob_tag;
    p.inst    = bus.wr_inst[k];
    p.NPC     = bus.wr_NPC[k];
    return p;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_expected();
    for (int i = 0; i < FU_N; i++) exp_q[i].delete();
  endtask

  // Record every handshake that will complete at the coming edge.
  always @(negedge clk) begin
    if (rst_n && !sq_now) begin
      for (int i = 0; i < FU_N; i++) begin
        if (bus.ex_packet_in[i].valid && bus.ex_ready[i]) exp_q[i].push_back(bus.ex_packet_in[i]);
      end
    end
  end

  // Monitor: every valid slot must be the oldest outstanding packet of its FU.
  always @(negedge clk) begin
    EX_WR_PACKET got;
    EX_WR_PACKET want;
    int f;
    cyc++;
    for (int k = 0; k < CDB_N; k++) begin
      got = slot_pkt(k);
      if (got.valid) begin
        n_out++;
        f = int'(got.value[11:8]);
        if (f >= FU_N || exp_q[f].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_slot%0d: got %0h, nothing pending", k, got);
        end else begin
          want = exp_q[f].pop_front();
          check($sformatf("slot%0d_fu%0d_data", k, f), got, want);
          if (win_en) begin
            wins[f]++;
            if (last_win[f] >= 0 && cyc - last_win[f] > max_gap[f]) max_gap[f] = cyc - last_win[f];
            last_win[f] = cyc;
          end
        end
      end else begin
        check($sformatf("slot%0d_idle_zero", k), got, '0);
      end
    end
  end

  initial begin
    logic [FU_N-1:0] acc;
    int              seq [FU_N];
    int              out_snap;

    clk   = 1'b0;
    rst_n = 1'b0;
`ifdef WR_SQUASH_EN
    squash = 1'b0;
`endif
    for (int i = 0; i < FU_N; i++) begin
      bus.ex_packet_in[i] = '0;
      wins[i] = 0; last_win[i] = -1; max_gap[i] = 0;
    end
    #1;

    // Reset with all four FUs requesting.
    for (int i = 0; i < FU_N; i++) bus.ex_packet_in[i] = make_pkt(i, i + 1);
    #12;
    check("t1_ready_in_reset", 128'(bus.ex_ready), 128'(4'b1111));
    check("t1_cdb_in_reset", {bus.cdb[0].valid, bus.cdb[1].valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);                                  // edge 1: all four pushed
    for (int i = 0; i < FU_N; i++) bus.ex_packet_in[i] = '0;
    check("t1_ready_edge1", 128'(bus.ex_ready), 128'(4'b1111));
    check("t1_cdb_edge1", {bus.cdb[0].valid, bus.cdb[1].valid}, 0);
    tick(1);                                  // edge 2
    check("t1_slot0_edge2", slot_pkt(0), make_pkt(0, 1));
    check("t1_slot1_edge2", slot_pkt(1), make_pkt(1, 2));
    tick(1);                                  // edge 3
    check("t2_slot0_edge3", slot_pkt(0), make_pkt(2, 3));
    check("t2_slot1_edge3", slot_pkt(1), make_pkt(3, 4));
    check("t2_rr_ptr", 128'(dut.rr_ptr), 0);
    tick(1);
    check("t2_idle_after", {bus.cdb[0].valid, bus.cdb[1].valid}, 0);

    // FU2 alone, back-to-back tags 5,6,7.
    bus.ex_packet_in[2] = make_pkt(2, 5);
    tick(1);
    bus.ex_packet_in[2] = make_pkt(2, 6);
    check("t3_ready2_a", 128'(bus.ex_ready[2]), 1);
    tick(1);
    check("t3_tag5", slot_pkt(0), make_pkt(2, 5));
    check("t3_slot1_idle_a", 128'(bus.cdb[1].valid), 0);
    bus.ex_packet_in[2] = make_pkt(2, 7);
    check("t3_ready2_b", 128'(bus.ex_ready[2]), 1);
    tick(1);
    bus.ex_packet_in[2] = '0;
    check("t3_tag6", slot_pkt(0), make_pkt(2, 6));
    tick(1);
    check("t3_tag7", slot_pkt(0), make_pkt(2, 7));
    check("t3_slot1_idle_b", 128'(bus.cdb[1].valid), 0);
    tick(1);
    check("t3_drained", 128'(bus.cdb[0].valid), 0);

    // Saturation: every FU pushes whenever ready.
    for (int i = 0; i < FU_N; i++) begin
      seq[i] = 32 + 16 * i;
      bus.ex_packet_in[i] = make_pkt(i, seq[i]);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < FU_N; i++) acc[i] = bus.ex_packet_in[i].valid && bus.ex_ready[i];
      @(posedge clk); #1;
      for (int i = 0; i < FU_N; i++) begin
        if (acc[i]) begin
          seq[i]++;
          bus.ex_packet_in[i] = make_pkt(i, seq[i]);
        end
      end
      if (c == 1) win_en = 1'b1;
      if (c == 9) win_en = 1'b0;
    end
    for (int i = 0; i < FU_N; i++) bus.ex_packet_in[i] = '0;
    for (int i = 0; i < FU_N; i++) begin
      check($sformatf("t4_wins_fu%0d", i), 128'(wins[i]), 4);
      check($sformatf("t4_gap_fu%0d", i), 128'(max_gap[i]), 2);
    end
    tick(8);
    for (int i = 0; i < FU_N; i++) check($sformatf("t4_drain_fu%0d", i), 128'(exp_q[i].size()), 0);

    // Async reset with packets on the CDB and two still buffered.
    for (int i = 0; i < FU_N; i++) bus.ex_packet_in[i] = make_pkt(i, 96 + i);
    tick(1);
    for (int i = 0; i < FU_N; i++) bus.ex_packet_in[i] = '0;
    tick(1);
    check("t5_busy_before", {bus.cdb[0].valid, bus.cdb[1].valid}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_cdb_async_clear", {bus.cdb[0].valid, bus.cdb[1].valid}, 0);
    check("t5_inst_npc_clear", {bus.wr_inst[0], bus.wr_inst[1], bus.wr_NPC[0], bus.wr_NPC[1]}, 0);
    clear_expected();
    tick(2);
    check("t5_ready_in_reset", 128'(bus.ex_ready), 128'(4'b1111));
    check("t5_rr_reset", 128'(dut.rr_ptr), 0);
    rst_n = 1'b1;
    out_snap = n_out;
    tick(5);
    check("t5_no_stale", 128'(n_out - out_snap), 0);

`ifdef WR_SQUASH_EN
    // Squash with three buffered and one push in the same cycle.
    for (int i = 0; i < FU_N; i++) bus.ex_packet_in[i] = make_pkt(i, 112 + i);
    tick(1);
    for (int i = 0; i < FU_N; i++) bus.ex_packet_in[i] = '0;
    bus.ex_packet_in[0] = make_pkt(0, 116);
    tick(1);
    check("t6_slot0_pre", slot_pkt(0), make_pkt(0, 112));
    check("t6_slot1_pre", slot_pkt(1), make_pkt(1, 113));
    bus.ex_packet_in[0] = '0;
    bus.ex_packet_in[1] = make_pkt(1, 117);
    squash = 1'b1;
    check("t6_ready_squash", 128'(bus.ex_ready), 128'(4'b1111));
    tick(1);
    squash = 1'b0;
    bus.ex_packet_in[1] = '0;
    clear_expected();
    check("t6_cdb_cleared", {bus.cdb[0].valid, bus.cdb[1].valid}, 0);
    check("t6_rr_hold", 128'(dut.rr_ptr), 2);
    out_snap = n_out;
    tick(5);
    check("t6_no_stale", 128'(n_out - out_snap), 0);
`endif

    for (int i = 0; i < FU_N; i++) check($sformatf("final_empty_fu%0d", i), 128'(exp_q[i].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
